// File: rtl/pe_ctrl_pkg.sv
// rtl/pe_ctrl_pkg.sv - shared sizes, FSM state type and lane vector type for the PE array sequencer
package pe_ctrl_pkg;

  localparam int ARRAY_SIZE = 8;   // input channels per tile
  localparam int BLOCK_H    = 8;   // output channels per tile
  localparam int ACC_W      = 32;  // partial-sum width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FIRE,
    ST_WAIT,
    ST_OUT,
    ST_DONE
  } state_e;

  typedef logic [BLOCK_H-1:0][ACC_W-1:0] lane_vec_t;

endpackage

// File: rtl/pe_acc_bank.sv
// rtl/pe_acc_bank.sv - per-lane partial-sum accumulator with bias load and clear
module pe_acc_bank
  import pe_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  logic      acc_en,
  input  logic      load_bias,
  input  lane_vec_t bias,
  input  lane_vec_t addend,
  output lane_vec_t acc
);

  lane_vec_t acc_q;
  lane_vec_t acc_d;

  // First input tile starts from the bias, later tiles add onto the running sum; wraps mod 2^ACC_W.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      for (int i = 0; i < BLOCK_H; i++) begin
        acc_d[i] = (load_bias ? bias[i] : acc_q[i]) + addend[i];
      end
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/pe_array_ctrl.sv
// rtl/pe_array_ctrl.sv - layer sequencer: buffer reads, array fire, cross-tile accumulation, result handshake
module pe_array_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int CNT_W  = 12,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_ic_tiles,
  input  logic [CNT_W-1:0]  cfg_oc_tiles,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ifm_rd_en,
  output logic [ADDR_W-1:0] ifm_rd_addr,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] b_rd_addr,
  input  lane_vec_t         b_rd_data,
  output logic              pe_i_en,
  input  logic              pe_valid,
  input  lane_vec_t         pe_ofmap,
  output logic              out_valid,
  input  logic              out_ready,
  output lane_vec_t         out_data,
  output logic [CNT_W-1:0]  out_oc
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   ic_tiles_q, ic_tiles_d;
  logic [CNT_W-1:0]   oc_tiles_q, oc_tiles_d;
  logic [CNT_W-1:0]   ic_q, ic_d;
  logic [CNT_W-1:0]   oc_q, oc_d;
  logic [ADDR_W-1:0]  w_addr_q, w_addr_d;
  logic               err_q, err_d;
  lane_vec_t          bias_q, bias_d;

  logic               start_acc;
  logic               acc_en;
  logic               first_ic;
  logic               last_ic;
  logic               last_oc;

  assign first_ic = (ic_q == '0);
  assign last_ic  = (ic_q == ic_tiles_q - CNT_W'(1));
  assign last_oc  = (oc_q == oc_tiles_q - CNT_W'(1));

  // Next-state, counter updates and per-state strobes.
  always_comb begin
    state_d    = state_q;
    ic_tiles_d = ic_tiles_q;
    oc_tiles_d = oc_tiles_q;
    ic_d       = ic_q;
    oc_d       = oc_q;
    w_addr_d   = w_addr_q;
    bias_d     = bias_q;
    start_acc  = 1'b0;
    acc_en     = 1'b0;
    ifm_rd_en  = 1'b0;
    w_rd_en    = 1'b0;
    b_rd_en    = 1'b0;
    pe_i_en    = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc  = 1'b1;
          ic_tiles_d = cfg_ic_tiles;
          oc_tiles_d = cfg_oc_tiles;
          ic_d       = '0;
          oc_d       = '0;
          w_addr_d   = '0;
          state_d    = (cfg_ic_tiles == '0 || cfg_oc_tiles == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        ifm_rd_en = 1'b1;
        w_rd_en   = 1'b1;
        b_rd_en   = first_ic;
        state_d   = ST_FIRE;
      end
      ST_FIRE: begin
        pe_i_en = 1'b1;
        if (first_ic) begin
          bias_d = b_rd_data;
        end
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (pe_valid) begin
          acc_en   = 1'b1;
          w_addr_d = w_addr_q + ADDR_W'(1);
          if (last_ic) begin
            state_d = ST_OUT;
          end else begin
            ic_d    = ic_q + CNT_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (last_oc) begin
            state_d = ST_DONE;
          end else begin
            oc_d    = oc_q + CNT_W'(1);
            ic_d    = '0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky error: a result arriving when no tile is in flight; a new layer clears it.
  always_comb begin
    err_d = err_q;
    if (start_acc) begin
      err_d = 1'b0;
    end
    if (pe_valid && state_q != ST_WAIT) begin
      err_d = 1'b1;
    end
  end

  // State, counters, latched config and bias register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ic_tiles_q <= '0;
      oc_tiles_q <= '0;
      ic_q       <= '0;
      oc_q       <= '0;
      w_addr_q   <= '0;
      err_q      <= 1'b0;
      bias_q     <= '0;
    end else begin
      state_q    <= state_d;
      ic_tiles_q <= ic_tiles_d;
      oc_tiles_q <= oc_tiles_d;
      ic_q       <= ic_d;
      oc_q       <= oc_d;
      w_addr_q   <= w_addr_d;
      err_q      <= err_d;
      bias_q     <= bias_d;
    end
  end

  pe_acc_bank u_acc (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_acc),
    .acc_en    (acc_en),
    .load_bias (first_ic),
    .bias      (bias_q),
    .addend    (pe_ofmap),
    .acc       (out_data)
  );

  assign busy        = (state_q != ST_IDLE);
  assign err         = err_q;
  assign ifm_rd_addr = ADDR_W'(ic_q);
  assign w_rd_addr   = w_addr_q;
  assign b_rd_addr   = ADDR_W'(oc_q);
  assign out_oc      = oc_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb/tb_pe_array_ctrl.sv - scoreboard bench for pe_array_ctrl with buffer and PE array responder
module tb_pe_array_ctrl;
  import pe_ctrl_pkg::*;

  logic        clk, rst, start;
  logic [11:0] cfg_ic_tiles, cfg_oc_tiles;
  logic        busy, done, err;
  logic        ifm_rd_en, w_rd_en, b_rd_en, pe_i_en, out_valid;
  logic [15:0] ifm_rd_addr, w_rd_addr, b_rd_addr;
  lane_vec_t   b_rd_data = '0;
  lane_vec_t   pe_ofmap = '0;
  lane_vec_t   out_data;
  logic        pe_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [11:0] out_oc;

  typedef struct {
    logic [11:0] oc;
    lane_vec_t   data;
  } exp_t;

  exp_t        sb[$];
  lane_vec_t   bias_m[16];
  lane_vec_t   ofm_m[64];
  lane_vec_t   last_exp;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ic_t = 0, oc_t = 0, fetch_n = 0, fire_n = 0, b_pulses = 0;
  int          hs_cycle = -1, st_cyc = 0, lat_fixed = 0;
  bit          hold_ready = 0, rand_ready = 0, stray_req = 0;

  pe_array_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_ic_tiles (cfg_ic_tiles),
    .cfg_oc_tiles (cfg_oc_tiles),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .ifm_rd_en    (ifm_rd_en),
    .ifm_rd_addr  (ifm_rd_addr),
    .w_rd_en      (w_rd_en),
    .w_rd_addr    (w_rd_addr),
    .b_rd_en      (b_rd_en),
    .b_rd_addr    (b_rd_addr),
    .b_rd_data    (b_rd_data),
    .pe_i_en      (pe_i_en),
    .pe_valid     (pe_valid),
    .pe_ofmap     (pe_ofmap),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_oc       (out_oc)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic lane_vec_t rand_vec();
    lane_vec_t v;
    for (int i = 0; i < BLOCK_H; i++) v[i] = $urandom;
    return v;
  endfunction

  function automatic lane_vec_t fill(logic [31:0] x);
    lane_vec_t v;
    for (int i = 0; i < BLOCK_H; i++) v[i] = x;
    return v;
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rd_en"}, {ifm_rd_en, w_rd_en, b_rd_en}, 0);
    chk({tag, "_pe_i_en"}, pe_i_en, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_addrs"}, {ifm_rd_addr, w_rd_addr, b_rd_addr}, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_oc"}, out_oc, 0);
  endtask

  // Buffer and PE array model: bias 1 cycle after read, result L_pe cycles after fire.
  initial begin
    bit        b_s, f_s;
    logic [15:0] ba_s;
    int        cnt, tile;
    cnt = 0;
    tile = 0;
    forever begin
      @(negedge clk);
      b_s  = b_rd_en;
      ba_s = b_rd_addr;
      f_s  = pe_i_en;
      @(posedge clk);
      #1;
      out_ready = hold_ready ? 1'b0 : (rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1);
      if (rst) begin
        cnt = 0;
        pe_valid = 0;
        continue;
      end
      b_rd_data = b_s ? bias_m[ba_s[3:0]] : rand_vec();
      pe_valid  = 0;
      pe_ofmap  = rand_vec();
      if (f_s) begin
        cnt  = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 4);
        tile = fire_n;
        fire_n++;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          pe_valid = 1;
          pe_ofmap = (tile < 64) ? ofm_m[tile] : rand_vec();
        end
      end
      if (stray_req) begin
        pe_valid  = 1;
        stray_req = 0;
      end
    end
  end

  // Monitor: read sequencing against tile order, output handshake against scoreboard.
  initial begin
    exp_t      e;
    int        ei, eo;
    bit        was_stall;
    lane_vec_t held_d;
    logic [11:0] held_oc;
    was_stall = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ifm_rd_en) begin
          if (ic_t == 0) begin
            chk("fetch_unexpected", 1, 0);
          end else begin
            ei = fetch_n % ic_t;
            eo = fetch_n / ic_t;
            chk("ifm_addr", ifm_rd_addr, ei);
            chk("w_addr", w_rd_addr, fetch_n);
            chk("w_en", w_rd_en, 1);
            chk("b_en", b_rd_en, (ei == 0));
            if (b_rd_en) chk("b_addr", b_rd_addr, eo);
          end
          fetch_n++;
        end else begin
          chk("rd_en_outside_fetch", {w_rd_en, b_rd_en}, 0);
        end
        if (b_rd_en) b_pulses++;
        if (out_valid) begin
          chk("no_fetch_during_out", ifm_rd_en, 0);
          if (was_stall) begin
            chk("stall_data_stable", out_data, held_d);
            chk("stall_oc_stable", out_oc, held_oc);
          end
          if (out_ready) begin
            if (sb.size() == 0) begin
              chk("sb_underflow", 1, 0);
            end else begin
              e = sb.pop_front();
              chk("out_oc", out_oc, e.oc);
              chk("out_data", out_data, e.data);
            end
            hs_cycle  = cyc;
            was_stall = 0;
          end else begin
            was_stall = 1;
            held_d    = out_data;
            held_oc   = out_oc;
          end
        end else begin
          was_stall = 0;
        end
      end else begin
        was_stall = 0;
      end
    end
  end

  // Reference: each oc tile is its bias plus the sum of its ic tiles' results, mod 2^32.
  task automatic start_layer(int ic, int oc);
    exp_t e;
    ic_t = ic;
    oc_t = oc;
    fetch_n = 0;
    fire_n = 0;
    b_pulses = 0;
    hs_cycle = -1;
    if (ic > 0) begin
      for (int o = 0; o < oc; o++) begin
        e.oc = 12'(o);
        for (int l = 0; l < BLOCK_H; l++) begin
          e.data[l] = bias_m[o][l];
          for (int i = 0; i < ic; i++) e.data[l] = e.data[l] + ofm_m[o * ic + i][l];
        end
        sb.push_back(e);
        last_exp = e.data;
      end
    end
    cfg_ic_tiles = 12'(ic);
    cfg_oc_tiles = 12'(oc);
    start  = 1;
    st_cyc = cyc;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1);
    chk("err_after_start", err, 0);
  endtask

  task automatic wait_done(int ic, int oc);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    if (done) begin
      if (ic == 0 || oc == 0) chk("done_latency_start", cyc, st_cyc + 1);
      else chk("done_latency_hs", cyc, hs_cycle + 1);
      chk("busy_during_done", busy, 1);
    end
    chk("sb_empty", sb.size(), 0);
    chk("fetch_count", fetch_n, ic * oc);
    chk("fire_count", fire_n, ic * oc);
    chk("bias_reads", b_pulses, (ic == 0) ? 0 : oc);
    chk("err_clean", err, 0);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_pulse_1cyc", done, 0);
  endtask

  task automatic run_layer(int ic, int oc);
    start_layer(ic, oc);
    wait_done(ic, oc);
  endtask

  initial begin
    int n, ic, oc;
    lane_vec_t d0;
    rst = 1;
    start = 0;
    cfg_ic_tiles = 0;
    cfg_oc_tiles = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 0;
    @(negedge clk);

    // single tile: bias 5 + ofmap 10
    bias_m[0] = fill(5);
    ofm_m[0]  = fill(10);
    run_layer(1, 1);

    // 3 input tiles x 2 output tiles, bias lane i = i, ofmap 1,2,3 per input tile
    for (int o = 0; o < 2; o++)
      for (int l = 0; l < BLOCK_H; l++) bias_m[o][l] = 32'(l);
    for (int k = 0; k < 6; k++) ofm_m[k] = fill(32'(k % 3 + 1));
    run_layer(3, 2);

    // two's-complement wrap
    bias_m[0] = fill(32'h7fff_ffff);
    ofm_m[0]  = fill(1);
    run_layer(1, 1);

    // stray result while idle
    stray_req = 1;
    repeat (3) @(negedge clk);
    chk("stray_err", err, 1);
    chk("stray_acc_kept", out_data, last_exp);

    // backpressure: ready low for 4 cycles on the first output
    for (int o = 0; o < 2; o++) bias_m[o] = rand_vec();
    for (int k = 0; k < 4; k++) ofm_m[k] = rand_vec();
    hold_ready = 1;
    start_layer(2, 2);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", out_valid, 1);
    d0 = out_data;
    repeat (4) begin
      chk("bp_valid_held", out_valid, 1);
      chk("bp_data_held", out_data, d0);
      chk("bp_no_fetch", ifm_rd_en, 0);
      @(negedge clk);
    end
    hold_ready = 0;
    wait_done(2, 2);

    // zero input tiles: straight to done, no reads, no fire
    run_layer(0, 3);

    // reset while waiting on tile 1 of a 3-tile layer
    for (int k = 0; k < 3; k++) ofm_m[k] = rand_vec();
    lat_fixed = 4;
    start_layer(3, 1);
    n = 0;
    while (fire_n < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rst_reached_tile1", fire_n, 2);
    rst = 1;
    @(negedge clk);
    check_zero("mid_rst");
    rst = 0;
    sb.delete();
    lat_fixed = 0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("mid_rst_no_done", n, 0);

    // randomized layers with random latency and random backpressure
    rand_ready = 1;
    repeat (6) begin
      ic = $urandom_range(1, 4);
      oc = $urandom_range(1, 4);
      for (int o = 0; o < oc; o++) bias_m[o] = rand_vec();
      for (int k = 0; k < ic * oc; k++) ofm_m[k] = rand_vec();
      run_layer(ic, oc);
    end
    rand_ready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
